axil_dma_csr: RTL and testbench

AXI4-Lite responder (slave) holding the DMA engine's control/status registers. Sits between the host-side AXI4-Lite bus, which the testbench drives through the AXI-Lite BFM, and the DMA datapath core. It decodes register reads and writes, produces a one-cycle start pulse plus static transfer descriptors for the core, latches done/error events from the core, and raises a level interrupt.

---
 rtl/axil_dma_csr_pkg.sv | 49 ++++
 rtl/axil_dma_csr_if.sv | 33 +++
 rtl/axil_dma_csr.sv | 156 +++++++++++++++
 tb/tb_axil_dma_csr.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_dma_csr_pkg.sv
// Shared constants and types for the DMA control/status register block:
// register offsets, bit positions, response codes and the address decoder.
package dma_csr_pkg;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h04;
    localparam logic [5:0] OFF_SRC    = 6'h08;
    localparam logic [5:0] OFF_DST    = 6'h0C;
    localparam logic [5:0] OFF_LEN    = 6'h10;
    localparam logic [5:0] OFF_ID     = 6'h14;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int STATUS_BUSY   = 0;
    localparam int STATUS_DONE   = 1;
    localparam int STATUS_ERR    = 2;

    localparam logic [31:0] ID_DEFAULT = 32'hD3A0_0100;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_STATUS,
        REG_SRC,
        REG_DST,
        REG_LEN,
        REG_ID,
        REG_NONE
    } reg_sel_e;

    // Any set address bit above [5] makes the access unmapped.
    function automatic reg_sel_e decode(input logic upper_zero, input logic [3:0] word);
        if (!upper_zero) return REG_NONE;
        case ({word, 2'b00})
            OFF_CTRL:   return REG_CTRL;
            OFF_STATUS: return REG_STATUS;
            OFF_SRC:    return REG_SRC;
            OFF_DST:    return REG_DST;
            OFF_LEN:    return REG_LEN;
            OFF_ID:     return REG_ID;
            default:    return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axil_dma_csr_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_dma_csr.sv
// AXI4-Lite responder for the DMA engine's control/status registers: start
// pulse, transfer descriptors, sticky done/error flags and a level interrupt.
module axil_dma_csr
    import dma_csr_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_lite_if.slave   axil,
    output logic        start_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [31:0] len_o,
    input  logic        busy_i,
    input  logic        done_i,
    input  logic        err_i,
    output logic        irq_o
);

    logic                  aw_held;
    logic                  w_held;
    reg_sel_e              aw_sel;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  irq_en;
    logic                  done;
    logic                  err;

    logic     aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic     wr_ctrl, wr_status, wr_src, wr_dst, wr_len;
    logic     start_req, clr_done, clr_err;
    resp_e    wr_resp;
    resp_e    rd_resp;
    reg_sel_e rd_sel;
    logic [31:0] rd_data;

    // Sub-word address bits and byte strobes carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{axil.awaddr[1:0], axil.araddr[1:0], axil.wstrb};

    assign axil.awready = rst_n & ~aw_held & ~axil.bvalid;
    assign axil.wready  = rst_n & ~w_held & ~axil.bvalid;
    assign axil.arready = rst_n & ~axil.rvalid;

    assign aw_hs  = axil.awvalid & axil.awready;
    assign w_hs   = axil.wvalid & axil.wready;
    assign b_hs   = axil.bvalid & axil.bready;
    assign ar_hs  = axil.arvalid & axil.arready;
    assign r_hs   = axil.rvalid & axil.rready;
    assign commit = aw_held & w_held & ~axil.bvalid;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wr_ctrl   = 1'b0;
        wr_status = 1'b0;
        wr_src    = 1'b0;
        wr_dst    = 1'b0;
        wr_len    = 1'b0;
        wr_resp   = (aw_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        if (commit) begin
            case (aw_sel)
                REG_CTRL:   wr_ctrl   = 1'b1;
                REG_STATUS: wr_status = 1'b1;
                REG_SRC:    wr_src    = 1'b1;
                REG_DST:    wr_dst    = 1'b1;
                REG_LEN:    wr_len    = 1'b1;
                default:    ;
            endcase
        end
        start_req = wr_ctrl & w_data[CTRL_START] & ~busy_i;
        clr_done  = wr_status & w_data[STATUS_DONE];
        clr_err   = wr_status & w_data[STATUS_ERR];
    end

    always_comb begin
        rd_sel  = decode(axil.araddr[ADDR_WIDTH-1:6] == '0, axil.araddr[5:2]);
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            REG_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
            REG_STATUS: begin
                rd_data[STATUS_BUSY] = busy_i;
                rd_data[STATUS_DONE] = done;
                rd_data[STATUS_ERR]  = err;
            end
            REG_SRC:    rd_data = src_addr_o;
            REG_DST:    rd_data = dst_addr_o;
            REG_LEN:    rd_data = len_o;
            REG_ID:     rd_data = ID_VALUE;
            default:    rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_sel      <= REG_NONE;
            w_data      <= '0;
            axil.bvalid <= 1'b0;
            axil.bresp  <= RESP_OKAY;
            axil.rvalid <= 1'b0;
            axil.rdata  <= '0;
            axil.rresp  <= RESP_OKAY;
            start_o     <= 1'b0;
            src_addr_o  <= '0;
            dst_addr_o  <= '0;
            len_o       <= '0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_sel  <= decode(axil.awaddr[ADDR_WIDTH-1:6] == '0, axil.awaddr[5:2]);
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= axil.wdata;
            end

            if (commit) begin
                axil.bvalid <= 1'b1;
                axil.bresp  <= wr_resp;
            end else if (b_hs) begin
                axil.bvalid <= 1'b0;
                aw_held     <= 1'b0;
                w_held      <= 1'b0;
            end

            start_o <= start_req;
            if (wr_ctrl) irq_en     <= w_data[CTRL_IRQ_EN];
            if (wr_src)  src_addr_o <= w_data;
            if (wr_dst)  dst_addr_o <= w_data;
            if (wr_len)  len_o      <= w_data;

            // A core event in the same cycle as a W1C clear keeps the flag set.
            done  <= done_i | (done & ~clr_done);
            err   <= err_i  | (err  & ~clr_err);
            irq_o <= irq_en & (done | err);

            if (ar_hs) begin
                axil.rvalid <= 1'b1;
                axil.rdata  <= rd_data;
                axil.rresp  <= rd_resp;
            end else if (r_hs) begin
                axil.rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_dma_csr.sv
// Scoreboard bench for axil_dma_csr: expected responses are queued at issue
// time from a register-map model and compared by independent channel monitors.
module tb_axil_dma_csr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_o;
    logic [31:0] src_addr_o, dst_addr_o, len_o;
    logic        busy_i, done_i, err_i;
    logic        irq_o;

    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

    axil_dma_csr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axil       (axil),
        .start_o    (start_o),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .len_o      (len_o),
        .busy_i     (busy_i),
        .done_i     (done_i),
        .err_i      (err_i),
        .irq_o      (irq_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int start_hi = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t bq[$];
    exp_t rq[$];

    // Register-map model: plain variables updated by address, not by cycle.
    logic [31:0] m_src, m_dst, m_len;
    logic        m_irq_en, m_done, m_err;
    int          m_pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_src = '0; m_dst = '0; m_len = '0;
        m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic busy, output logic [1:0] resp);
        resp = (addr < 32'h18) ? 2'b00 : 2'b10;
        if (addr < 32'h18) begin
            case (addr[31:2])
                30'd0: begin
                    if (data[0] && !busy) m_pulses++;
                    m_irq_en = data[1];
                end
                30'd1: begin
                    if (data[1]) m_done = 1'b0;
                    if (data[2]) m_err  = 1'b0;
                end
                30'd2: m_src = data;
                30'd3: m_dst = data;
                30'd4: m_len = data;
                default: ;
            endcase
        end
    endtask

    task automatic model_read(input logic [31:0] addr, input logic busy,
                              output logic [31:0] data, output logic [1:0] resp);
        data = '0;
        resp = (addr < 32'h18) ? 2'b00 : 2'b10;
        if (addr < 32'h18) begin
            case (addr[31:2])
                30'd0: data = {30'd0, m_irq_en, 1'b0};
                30'd1: data = {29'd0, m_err, m_done, busy};
                30'd2: data = m_src;
                30'd3: data = m_dst;
                30'd4: data = m_len;
                default: data = 32'hD3A0_0100;
            endcase
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (start_o) start_hi++;
        if (axil.bvalid && axil.bready) begin
            check("b_expected", bq.size() != 0 ? 32'd1 : 32'd0, 32'd1);
            if (bq.size() != 0) begin
                e = bq.pop_front();
                check($sformatf("bresp@%h", e.addr), {30'd0, axil.bresp}, {30'd0, e.resp});
            end
        end
        if (axil.rvalid && axil.rready) begin
            check("r_expected", rq.size() != 0 ? 32'd1 : 32'd0, 32'd1);
            if (rq.size() != 0) begin
                e = rq.pop_front();
                check($sformatf("rresp@%h", e.addr), {30'd0, axil.rresp}, {30'd0, e.resp});
                check($sformatf("rdata@%h", e.addr), axil.rdata, e.data);
            end
        end
    end

    // Waits for the channel's ready at a negedge, then completes the handshake.
    task automatic wait_ready(input int ch);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            case (ch)
                0:       ok = axil.awready;
                1:       ok = axil.wready;
                default: ok = axil.arready;
            endcase
        end
        if (!ok) check($sformatf("handshake_ch%0d_timeout", ch), 32'(ok), 32'd1);
        @(posedge clk); #1;
        case (ch)
            0:       axil.awvalid = 1'b0;
            1:       axil.wvalid  = 1'b0;
            default: axil.arvalid = 1'b0;
        endcase
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_lead, input int w_lead, input int b_stall,
                            input bit done_at_commit);
        exp_t e;
        logic [1:0] r;
        bit ok = 1'b0;
        model_write(addr, data, busy_i, r);
        if (done_at_commit) m_done = 1'b1;
        e.addr = addr; e.data = '0; e.resp = r;
        bq.push_back(e);
        @(posedge clk); #1;
        fork
            begin
                repeat (aw_lead) begin @(posedge clk); #1; end
                axil.awaddr = addr; axil.awvalid = 1'b1;
                wait_ready(0);
            end
            begin
                repeat (w_lead) begin @(posedge clk); #1; end
                axil.wdata = data; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
                wait_ready(1);
            end
        join
        if (done_at_commit) begin
            done_i = 1'b1;
            @(posedge clk); #1;
            done_i = 1'b0;
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = axil.bvalid;
        end
        if (!ok) check("bvalid_timeout", 32'(ok), 32'd1);
        for (int i = 0; i < b_stall; i++) begin
            @(negedge clk);
            check("stall_bvalid",  32'(axil.bvalid),  32'd1);
            check("stall_awready", 32'(axil.awready), 32'd0);
            check("stall_wready",  32'(axil.wready),  32'd0);
        end
        @(posedge clk); #1;
        axil.bready = 1'b1;
        @(posedge clk); #1;
        axil.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_stall);
        exp_t e;
        logic [31:0] d;
        logic [1:0]  r;
        bit ok = 1'b0;
        model_read(addr, busy_i, d, r);
        e.addr = addr; e.data = d; e.resp = r;
        rq.push_back(e);
        @(posedge clk); #1;
        axil.araddr = addr; axil.arvalid = 1'b1;
        wait_ready(2);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = axil.rvalid;
        end
        if (!ok) check("rvalid_timeout", 32'(ok), 32'd1);
        for (int i = 0; i < r_stall; i++) begin
            @(negedge clk);
            check("stall_rvalid", 32'(axil.rvalid), 32'd1);
        end
        @(posedge clk); #1;
        axil.rready = 1'b1;
        @(posedge clk); #1;
        axil.rready = 1'b0;
    endtask

    task automatic pulse_event(input bit is_err);
        @(posedge clk); #1;
        if (is_err) err_i = 1'b1; else done_i = 1'b1;
        @(posedge clk); #1;
        err_i = 1'b0; done_i = 1'b0;
        if (is_err) m_err = 1'b1; else m_done = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_src"},    src_addr_o, m_src);
        check({tag, "_dst"},    dst_addr_o, m_dst);
        check({tag, "_len"},    len_o,      m_len);
        check({tag, "_irq"},    32'(irq_o), 32'(m_irq_en & (m_done | m_err)));
        check({tag, "_starts"}, start_hi,   m_pulses);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] a, d;
        int sel;
        rst_n = 1'b0;
        busy_i = 1'b0; done_i = 1'b0; err_i = 1'b0;
        axil.awvalid = 1'b0; axil.awaddr = '0;
        axil.wvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
        axil.bready = 1'b0;
        axil.arvalid = 1'b0; axil.araddr = '0;
        axil.rready = 1'b0;
        m_pulses = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_awready", 32'(axil.awready), 32'd0);
        check("rst_wready",  32'(axil.wready),  32'd0);
        check("rst_arready", 32'(axil.arready), 32'd0);
        check("rst_bvalid",  32'(axil.bvalid),  32'd0);
        check("rst_rvalid",  32'(axil.rvalid),  32'd0);
        check("rst_bresp",   {30'd0, axil.bresp}, 32'd0);
        check("rst_rresp",   {30'd0, axil.rresp}, 32'd0);
        check("rst_rdata",   axil.rdata, 32'd0);
        check("rst_start",   32'(start_o), 32'd0);
        check("rst_irq",     32'(irq_o),   32'd0);
        check("rst_src",     src_addr_o, 32'd0);
        check("rst_len",     len_o,      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Descriptor registers write and read back.
        do_write(32'h08, 32'h0000_1000, 0, 0, 0, 0);
        do_write(32'h0C, 32'h0000_2000, 1, 0, 0, 0);
        do_write(32'h10, 32'h0000_0040, 0, 1, 0, 0);
        do_read(32'h08, 0);
        do_read(32'h0C, 1);
        do_read(32'h10, 0);
        check_outputs("desc");

        // Start pulse, then start suppressed while busy.
        do_write(32'h00, 32'h3, 0, 0, 0, 0);
        check_outputs("start_idle");
        do_read(32'h00, 0);
        busy_i = 1'b1;
        do_write(32'h00, 32'h3, 0, 0, 0, 0);
        check_outputs("start_busy");
        do_read(32'h04, 0);
        busy_i = 1'b0;

        // Done flag, interrupt, W1C and set-wins-over-clear.
        pulse_event(1'b0);
        check_outputs("done_set");
        do_read(32'h04, 0);
        do_write(32'h04, 32'h2, 0, 0, 0, 0);
        check_outputs("done_clr");
        do_read(32'h04, 0);
        pulse_event(1'b0);
        do_write(32'h04, 32'h2, 0, 0, 0, 1);
        check_outputs("done_race");
        do_read(32'h04, 0);
        pulse_event(1'b1);
        do_read(32'h04, 0);
        do_write(32'h04, 32'h6, 0, 0, 0, 0);
        check_outputs("err_clr");

        // ID register is read-only.
        do_read(32'h14, 0);
        do_write(32'h14, 32'hFFFF_FFFF, 0, 0, 0, 0);
        do_read(32'h14, 0);

        // Unmapped offsets and high address bits.
        do_read(32'h20, 0);
        do_write(32'h20, 32'hDEAD_BEEF, 0, 0, 0, 0);
        do_write(32'h0000_0048, 32'hCAFE_F00D, 0, 0, 0, 0);
        do_read(32'h0000_0108, 0);
        check_outputs("unmapped");

        // W two cycles ahead of AW, B held off for five cycles.
        do_write(32'h00, 32'h3, 2, 0, 5, 0);
        check_outputs("stall");

        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4, 5: a = 32'(sel * 4);
                6:       a = 32'h18 + 32'(4 * $urandom_range(0, 9));
                7:       a = 32'(32'h40 * $urandom_range(1, 1000)) + 32'(4 * $urandom_range(0, 5));
                default: a = 32'h08 + 32'(4 * $urandom_range(0, 2));
            endcase
            a = a | 32'($urandom_range(0, 3));
            d = $urandom;
            @(posedge clk); #1;
            busy_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) pulse_event($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), 0);
            else
                do_read(a, $urandom_range(0, 2));
            check_outputs("rand");
        end
        busy_i = 1'b0;

        // Reset lands on the edge after a completed AW/W handshake.
        @(posedge clk); #1;
        axil.awaddr = 32'h08; axil.awvalid = 1'b1;
        axil.wdata = 32'h1234_5678; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_bvalid",  32'(axil.bvalid),  32'd0);
        check("midrst_awready", 32'(axil.awready), 32'd0);
        check("midrst_src",     src_addr_o,        32'd0);
        check("midrst_irq",     32'(irq_o),        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        do_read(32'h08, 0);
        do_read(32'h00, 0);
        check_outputs("post_rst");

        for (int i = 0; i < 20 && (bq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
        check("b_queue_drained", bq.size(), 32'd0);
        check("r_queue_drained", rq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
